muldiv_sequencer: RTL and testbench

- Multi-cycle iterative unsigned multiply/divide engine with architectural HI/LO registers. It sits beside the EX-stage ALU and runs MULTU/DIVU/MTHI/MTLO without the single-cycle combinational 64-bit product or 32-bit divider.
- The pipeline controller issues one operation with a start pulse, reads HI/LO for MFHI/MFLO, and stalls on md_stall.
- The operation encoding matches the ALU: 3 = unsigned multiply, 4 = unsigned divide.

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative unsigned MULTU/DIVU engine with HI/LO (MTHI/MTLO too).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] md_a_data,
    input  logic [WIDTH-1:0] md_b_data,
    input  logic             md_cancel,
    input  logic             md_rd_hilo,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_stall,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [3:0] c_OP_MULTU = 4'b0011;
    localparam logic [3:0] c_OP_DIVU  = 4'b0100;
    localparam logic [3:0] c_OP_MTHI  = 4'b1101;
    localparam logic [3:0] c_OP_MTLO  = 4'b1110;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_sr;
    logic [WIDTH-1:0]   w_div_sub;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_acc;
    logic               w_accept;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign w_mul_acc = {w_mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {remainder, quotient}; remainder < divisor keeps the sub in WIDTH bits.
    assign w_div_sr  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_div_ok  = (w_div_sr >= {1'b0, b_q});
    assign w_div_sub = w_div_sr[WIDTH-1:0] - b_q;
    assign w_div_acc = w_div_ok ? {w_div_sub, acc_q[WIDTH-2:0], 1'b1}
                                : {w_div_sr[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign w_accept = md_start & ~md_cancel & ((state_q == c_IDLE) | (state_q == c_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            c_MUL: begin
                if (md_cancel) begin
                    state_d = c_IDLE;
                end else begin
                    acc_d = w_mul_acc;
                    cnt_d = cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        hi_d    = w_mul_acc[2*WIDTH-1:WIDTH];
                        lo_d    = w_mul_acc[WIDTH-1:0];
                        state_d = c_DONE;
                    end
                end
            end
            c_DIV: begin
                if (md_cancel) begin
                    state_d = c_IDLE;
                end else begin
                    acc_d = w_div_acc;
                    cnt_d = cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        hi_d    = w_div_acc[2*WIDTH-1:WIDTH];
                        lo_d    = w_div_acc[WIDTH-1:0];
                        state_d = c_DONE;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                if (w_accept) begin
                    case (md_op)
                        c_OP_MULTU: begin
                            a_d     = md_a_data;
                            b_d     = md_b_data;
                            acc_d   = {{WIDTH{1'b0}}, md_b_data};
                            cnt_d   = c_CNT_INIT;
                            state_d = c_MUL;
                        end
                        c_OP_DIVU: begin
                            if (md_b_data == '0) begin
                                hi_d    = md_a_data;
                                lo_d    = '1;
                                state_d = c_DONE;
                            end else begin
                                a_d     = md_a_data;
                                b_d     = md_b_data;
                                acc_d   = {{WIDTH{1'b0}}, md_a_data};
                                cnt_d   = c_CNT_INIT;
                                state_d = c_DIV;
                            end
                        end
                        c_OP_MTHI: hi_d = md_a_data;
                        c_OP_MTLO: lo_d = md_a_data;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md_busy  = (state_q == c_MUL) | (state_q == c_DIV);
    assign md_done  = (state_q == c_DONE);
    assign md_stall = md_busy & (md_start | md_rd_hilo);
    assign md_hi    = hi_q;
    assign md_lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Directed self-checking bench against an arithmetic HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         md_start;
    logic [3:0]   md_op;
    logic [W-1:0] md_a_data;
    logic [W-1:0] md_b_data;
    logic         md_cancel;
    logic         md_rd_hilo;
    logic         md_busy;
    logic         md_done;
    logic         md_stall;
    logic [W-1:0] md_hi;
    logic [W-1:0] md_lo;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_a_data  (md_a_data),
        .md_b_data  (md_b_data),
        .md_cancel  (md_cancel),
        .md_rd_hilo (md_rd_hilo),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_stall   (md_stall),
        .md_hi      (md_hi),
        .md_lo      (md_lo)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    endtask

    // Transaction-level model: results from plain * / %, timing from a countdown.
    int           m_rem  = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                if (md_cancel) m_rem <= 0;
                else if (m_rem == 1) begin
                    m_rem  <= 0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end else m_rem <= m_rem - 1;
            end else if (md_start && !md_cancel) begin
                case (md_op)
                    4'd3: begin
                        {p_hi, p_lo} <= 64'(md_a_data) * 64'(md_b_data);
                        m_rem <= W;
                    end
                    4'd4: begin
                        if (md_b_data == 0) begin
                            m_done <= 1'b1;
                            m_hi   <= md_a_data;
                            m_lo   <= '1;
                        end else begin
                            p_hi  <= md_a_data % md_b_data;
                            p_lo  <= md_a_data / md_b_data;
                            m_rem <= W;
                        end
                    end
                    4'd13: m_hi <= md_a_data;
                    4'd14: m_lo <= md_a_data;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",  64'(md_busy),  64'(m_rem > 0));
            chk("cyc_done",  64'(md_done),  64'(m_done));
            chk("cyc_stall", 64'(md_stall), 64'((m_rem > 0) && (md_start || md_rd_hilo)));
            chk("cyc_hi",    64'(md_hi),    64'(m_hi));
            chk("cyc_lo",    64'(md_lo),    64'(m_lo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int wait_cyc, output int busy_cyc);
        md_start  = 1'b1;
        md_op     = op;
        md_a_data = a;
        md_b_data = b;
        tick();
        md_start  = 1'b0;
        wait_cyc  = 0;
        busy_cyc  = 0;
        while (!md_done && wait_cyc < 40) begin
            if (md_busy) busy_cyc++;
            wait_cyc++;
            tick();
        end
        chk("done_seen", 64'(md_done), 64'd1);
    endtask

    int wc, bc, k, stall_cnt;

    initial begin
        rst = 1'b1; md_start = 1'b0; md_op = 4'd0; md_a_data = '0; md_b_data = '0;
        md_cancel = 1'b0; md_rd_hilo = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hi", 64'(md_hi), 64'd0);
        chk("rst_lo", 64'(md_lo), 64'd0);
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_done", 64'(md_done), 64'd0);
        tick();

        // 7*6 with latency
        run_op(4'd3, 32'd7, 32'd6, wc, bc);
        chk("mul1_wait", 64'(wc), 64'd32);
        chk("mul1_busy", 64'(bc), 64'd32);
        chk("mul1_hi", 64'(md_hi), 64'h0);
        chk("mul1_lo", 64'(md_lo), 64'h2A);
        chk("model_mul1_lo", 64'(m_lo), 64'h2A);
        tick();

        // max*max, then DIVU issued in its DONE cycle
        run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, wc, bc);
        chk("mul2_hi", 64'(md_hi), 64'hFFFF_FFFE);
        chk("mul2_lo", 64'(md_lo), 64'h1);
        chk("model_mul2_hi", 64'(m_hi), 64'hFFFF_FFFE);
        run_op(4'd4, 32'd100, 32'd7, wc, bc);
        chk("div1_wait", 64'(wc), 64'd32);
        chk("div1_hi", 64'(md_hi), 64'd2);
        chk("div1_lo", 64'(md_lo), 64'd14);
        chk("model_div1_lo", 64'(m_lo), 64'd14);
        tick();

        // divide by zero
        run_op(4'd4, 32'd5, 32'd0, wc, bc);
        chk("dz_wait", 64'(wc), 64'd0);
        chk("dz_busy", 64'(bc), 64'd0);
        chk("dz_hi", 64'(md_hi), 64'h5);
        chk("dz_lo", 64'(md_lo), 64'hFFFF_FFFF);
        tick();

        // MTHI / MTLO, then cancelled MULTU
        md_start = 1'b1; md_op = 4'b1101; md_a_data = 32'h1234_5678;
        tick();
        md_start = 1'b0;
        chk("mthi_hi", 64'(md_hi), 64'h1234_5678);
        chk("mthi_done", 64'(md_done), 64'd0);
        md_start = 1'b1; md_op = 4'b1110; md_a_data = 32'h9ABC_DEF0;
        tick();
        md_start = 1'b0;
        chk("mtlo_lo", 64'(md_lo), 64'h9ABC_DEF0);
        chk("mtlo_done", 64'(md_done), 64'd0);
        md_start = 1'b1; md_op = 4'd3; md_a_data = 32'd3; md_b_data = 32'd4;
        tick();
        md_start = 1'b0;
        repeat (9) tick();
        md_cancel = 1'b1;
        tick();
        md_cancel = 1'b0;
        chk("cancel_busy", 64'(md_busy), 64'd0);
        chk("cancel_hi", 64'(md_hi), 64'h1234_5678);
        chk("cancel_lo", 64'(md_lo), 64'h9ABC_DEF0);
        tick();
        chk("cancel_nodone", 64'(md_done), 64'd0);
        repeat (2) tick();

        // stall on held start / rd_hilo during DIVU; held MULTU taken in DONE
        md_start = 1'b1; md_op = 4'd4; md_a_data = 32'd1000; md_b_data = 32'd3;
        tick();
        md_op = 4'd3; md_a_data = 32'd5; md_b_data = 32'd9; md_rd_hilo = 1'b1;
        stall_cnt = 0; k = 0;
        while (!md_done && k < 40) begin
            if (md_stall) stall_cnt++;
            k++;
            tick();
        end
        chk("stall_done_seen", 64'(md_done), 64'd1);
        chk("stall_cycles", 64'(stall_cnt), 64'd32);
        chk("stall_in_done", 64'(md_stall), 64'd0);
        chk("div2_hi", 64'(md_hi), 64'd1);
        chk("div2_lo", 64'(md_lo), 64'd333);
        tick();
        md_start = 1'b0; md_rd_hilo = 1'b0;
        chk("held_mul_busy", 64'(md_busy), 64'd1);
        k = 0;
        while (!md_done && k < 40) begin
            k++;
            tick();
        end
        chk("held_mul_done_seen", 64'(md_done), 64'd1);
        chk("held_mul_lo", 64'(md_lo), 64'd45);
        chk("held_mul_hi", 64'(md_hi), 64'd0);
        tick();

        // reset in the middle of MULTU 3*3
        md_start = 1'b1; md_op = 4'd3; md_a_data = 32'd3; md_b_data = 32'd3;
        tick();
        md_start = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 64'(md_busy), 64'd0);
        chk("mrst_done", 64'(md_done), 64'd0);
        chk("mrst_hi", 64'(md_hi), 64'd0);
        chk("mrst_lo", 64'(md_lo), 64'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
